stream_fifo32: RTL

Elastic 32-bit stream buffer with valid/ready handshakes on both sides. It decouples a producing pipeline stage from a consuming stage that may stall, such as the exponent/accumulate stages feeding the normaliser in the softmax datapath. It is the consumer-facing counterpart to the plain enable-loaded pipeline registers. Data is stored in a small circular buffer and read out first-word-fall-through, so the head word is visible whenever `out_valid` is high.

---
 rtl/stream_fifo32.sv | 56 +++++
 1 files changed

// File: rtl/stream_fifo32.sv
// stream_fifo32: elastic valid/ready FWFT buffer; define STREAM_FIFO_BYPASS_EN for an empty-buffer bypass path
module stream_fifo32 #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic empty, full, push, pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign in_ready = !full && !flush;
`ifdef STREAM_FIFO_BYPASS_EN
  logic byp;
  assign byp = empty && !flush && in_valid;
  assign out_valid = (!empty && !flush) || byp;
  assign out_data = empty ? in_data : mem[rp];
  assign push = in_valid && in_ready && !(byp && out_ready);
  assign pop = out_valid && out_ready && !byp;
`else
  assign out_valid = !empty && !flush;
  assign out_data = mem[rp];
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
`endif
  // storage write; contents are never reset, validity is tracked by count
  always_ff @(posedge clk)
    if (push) mem[wp] <= in_data;
  // pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule
